// File: rtl/instr_decode.sv
// MIPS decode stage: field split, ALU opcode, immediate/target generation, one-entry
// output register and a busy-bit scoreboard that stalls on RAW/WAW hazards.
module instr_decode (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [8:0]  out_alu_op,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic [31:0] out_imm,
   output logic [31:0] out_target,
   output logic [31:0] out_pc,
   output logic        out_illegal
);

   logic [5:0]  opcode, funct;
   logic [4:0]  f_rs, f_rt, f_rd, shamt;
   logic [15:0] imm16;
   logic [31:0] sext16, pc4;
   logic        cls_r, cls_j, cls_br, cls_ialu, cls_ld, cls_st, funct_ok;
   logic        illegal, has_dest, wen, use_rs, use_rt, hazard, accept;
   logic [8:0]  alu_op;
   logic [4:0]  dest;
   logic [31:0] imm, target;
   logic [31:0] wb_clr, block;

   logic        out_valid_d, out_valid_q;
   logic [8:0]  out_alu_op_d, out_alu_op_q;
   logic [4:0]  out_rs_d, out_rs_q, out_rt_d, out_rt_q, out_rd_d, out_rd_q;
   logic        out_wen_d, out_wen_q, out_illegal_d, out_illegal_q;
   logic [31:0] out_imm_d, out_imm_q, out_target_d, out_target_q, out_pc_d, out_pc_q;
   logic [31:0] busy_d, busy_q;

   assign opcode = in_instr[31:26];
   assign f_rs   = in_instr[25:21];
   assign f_rt   = in_instr[20:16];
   assign f_rd   = in_instr[15:11];
   assign shamt  = in_instr[10:6];
   assign funct  = in_instr[5:0];
   assign imm16  = in_instr[15:0];
   assign sext16 = {{16{imm16[15]}}, imm16};
   assign pc4    = in_pc + 32'd4;

   always_comb begin
      cls_r    = (opcode == 6'h00);
      cls_j    = (opcode[5:1] == 5'b00001);
      cls_br   = (opcode[5:2] == 4'b0001);
      cls_ialu = (opcode[5:3] == 3'b001);
      cls_ld   = (opcode >= 6'h20) && (opcode <= 6'h25);
      cls_st   = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B: funct_ok = 1'b1;
         default:      funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      alu_op   = {3'b111, opcode};
      dest     = 5'd0;
      has_dest = 1'b0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      target   = 32'd0;
      illegal  = 1'b0;
      if (cls_r) begin
         if (funct_ok) begin
            alu_op   = {3'b000, funct};
            dest     = f_rd;
            has_dest = (funct != 6'h08);
            use_rs   = 1'b1;
            use_rt   = 1'b1;
         end else begin
            alu_op  = {3'b111, funct};
            illegal = 1'b1;
         end
      end else if (cls_ialu || cls_ld) begin
         alu_op   = {(cls_ialu ? 3'b001 : 3'b010), opcode};
         dest     = f_rt;
         has_dest = 1'b1;
         use_rs   = 1'b1;
      end else if (cls_st) begin
         alu_op = {3'b010, opcode};
         use_rs = 1'b1;
         use_rt = 1'b1;
      end else if (cls_br) begin
         // BEQ/BNE compare two registers, BLEZ/BGTZ only rs
         alu_op = {3'b011, opcode};
         use_rs = 1'b1;
         use_rt = !opcode[1];
         target = pc4 + {sext16[29:0], 2'b00};
      end else if (cls_j) begin
         alu_op   = {3'b100, opcode};
         dest     = 5'd31;
         has_dest = opcode[0];
         target   = {pc4[31:28], in_instr[25:0], 2'b00};
      end else begin
         illegal = 1'b1;
      end
      if (!has_dest) dest = 5'd0;
      wen = has_dest && (dest != 5'd0);

      if (cls_r)                                        imm = {27'd0, shamt};
      else if (opcode >= 6'h0C && opcode <= 6'h0E)      imm = {16'd0, imm16};
      else if (opcode == 6'h0F)                         imm = {imm16, 16'd0};
      else                                              imm = sext16;
   end

   // A register released by writeback this cycle no longer blocks.
   always_comb begin
      wb_clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;
      block  = busy_q & ~wb_clr;
      if (out_valid_q && out_wen_q) block = block | (32'd1 << out_rd_q);
      hazard = !illegal && ((use_rs && block[f_rs]) || (use_rt && block[f_rt]) ||
                            (wen && block[dest]));
      in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
      accept   = in_valid && in_ready;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_alu_op_d  = out_alu_op_q;
      out_rs_d      = out_rs_q;
      out_rt_d      = out_rt_q;
      out_rd_d      = out_rd_q;
      out_wen_d     = out_wen_q;
      out_imm_d     = out_imm_q;
      out_target_d  = out_target_q;
      out_pc_d      = out_pc_q;
      out_illegal_d = out_illegal_q;
      if (accept) begin
         out_valid_d   = 1'b1;
         out_alu_op_d  = alu_op;
         out_rs_d      = f_rs;
         out_rt_d      = f_rt;
         out_rd_d      = dest;
         out_wen_d     = wen;
         out_imm_d     = imm;
         out_target_d  = target;
         out_pc_d      = in_pc;
         out_illegal_d = illegal;
      end else if (flush || out_ready) begin
         out_valid_d = 1'b0;
      end

      // set after clear so a same-register handoff wins over writeback
      busy_d = busy_q & ~wb_clr;
      if (out_valid_q && out_ready && out_wen_q) busy_d[out_rd_q] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q   <= 1'b0;
         out_alu_op_q  <= 9'd0;
         out_rs_q      <= 5'd0;
         out_rt_q      <= 5'd0;
         out_rd_q      <= 5'd0;
         out_wen_q     <= 1'b0;
         out_imm_q     <= 32'd0;
         out_target_q  <= 32'd0;
         out_pc_q      <= 32'd0;
         out_illegal_q <= 1'b0;
         busy_q        <= 32'd0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_alu_op_q  <= out_alu_op_d;
         out_rs_q      <= out_rs_d;
         out_rt_q      <= out_rt_d;
         out_rd_q      <= out_rd_d;
         out_wen_q     <= out_wen_d;
         out_imm_q     <= out_imm_d;
         out_target_q  <= out_target_d;
         out_pc_q      <= out_pc_d;
         out_illegal_q <= out_illegal_d;
         busy_q        <= busy_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_alu_op  = out_alu_op_q;
   assign out_rs      = out_rs_q;
   assign out_rt      = out_rt_q;
   assign out_rd      = out_rd_q;
   assign out_wen     = out_wen_q;
   assign out_imm     = out_imm_q;
   assign out_target  = out_target_q;
   assign out_pc      = out_pc_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: decode vector table, hazard/flush/reset sequences and a
// randomized run against a behavioural decode + scoreboard model.
module tb_instr_decode;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_instr = 32'd0, in_pc = 32'd0;
   logic        flush = 1'b0, wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic        out_valid, out_ready = 1'b0;
   logic [8:0]  out_alu_op;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic        out_wen, out_illegal;
   logic [31:0] out_imm, out_target, out_pc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   instr_decode dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_wen(out_wen),
      .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
      .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [8:0]  alu;
      logic [4:0]  rs, rt, rd;
      logic        wen;
      logic [31:0] imm, target, pc;
      logic        ill;
      logic        use_rs, use_rt;
   } dec_t;

   typedef struct {
      logic [31:0] instr, pc;
      logic [8:0]  alu;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] imm, target;
      logic        ill;
   } vec_t;

   vec_t tbl[14];

   logic [31:0] m_busy;
   logic        m_valid;
   dec_t        m_held;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; flush = 0; wb_valid = 0; out_ready = 0;
      reset_n = 0;
      #1;
      step();
      reset_n = 1;
      #1;
   endtask

   function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      dec_t d;
      logic [5:0]  op, fn;
      logic [4:0]  dst;
      logic [31:0] sx, pc4;
      op  = ins[31:26];
      fn  = ins[5:0];
      sx  = {{16{ins[15]}}, ins[15:0]};
      pc4 = pc + 32'd4;
      dst = 5'd0;
      d = '0;
      d.rs = ins[25:21];
      d.rt = ins[20:16];
      d.pc = pc;
      if (op == 6'd0)                                d.imm = {27'd0, ins[10:6]};
      else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) d.imm = {16'd0, ins[15:0]};
      else if (op == 6'h0F)                          d.imm = {ins[15:0], 16'd0};
      else                                           d.imm = sx;
      if (op == 6'd0) begin
         if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
                        [6'h20:6'h27], 6'h2A, 6'h2B}) begin
            d.alu = {3'b000, fn};
            d.use_rs = 1; d.use_rt = 1;
            dst = (fn == 6'h08) ? 5'd0 : ins[15:11];
         end else begin
            d.alu = {3'b111, fn};
            d.ill = 1;
         end
      end else if (op == 6'h02 || op == 6'h03) begin
         d.alu = {3'b100, op};
         d.target = {pc4[31:28], ins[25:0], 2'b00};
         dst = (op == 6'h03) ? 5'd31 : 5'd0;
      end else if (op >= 6'h04 && op <= 6'h07) begin
         d.alu = {3'b011, op};
         d.target = pc4 + sx * 4;
         d.use_rs = 1;
         d.use_rt = (op < 6'h06);
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         d.alu = {3'b001, op};
         d.use_rs = 1;
         dst = ins[20:16];
      end else if (op >= 6'h20 && op <= 6'h25) begin
         d.alu = {3'b010, op};
         d.use_rs = 1;
         dst = ins[20:16];
      end else if (op == 6'h28 || op == 6'h29 || op == 6'h2B) begin
         d.alu = {3'b010, op};
         d.use_rs = 1; d.use_rt = 1;
      end else begin
         d.alu = {3'b111, op};
         d.ill = 1;
      end
      d.rd  = dst;
      d.wen = (dst != 5'd0);
      return d;
   endfunction

   function automatic logic blk(input logic [4:0] r);
      return (m_busy[r] && !(wb_valid && wb_rd == r)) ||
             (m_valid && m_held.wen && m_held.rd == r);
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd;
      int k;
      k  = $urandom_range(0, 19);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      if (k < 5)       op = 6'd0;
      else if (k < 7)  op = 6'($urandom_range(2, 3));
      else if (k < 10) op = 6'($urandom_range(4, 7));
      else if (k < 14) op = 6'($urandom_range(8, 15));
      else if (k < 16) op = 6'($urandom_range(32, 37));
      else if (k < 18) begin
         case ($urandom_range(0, 2))
            0:       op = 6'h28;
            1:       op = 6'h29;
            default: op = 6'h2B;
         endcase
      end else op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
         k = $urandom_range(0, 15);
         case (k)
            0: fn = 6'h00;  1: fn = 6'h02;  2: fn = 6'h03;  3: fn = 6'h04;
            4: fn = 6'h06;  5: fn = 6'h07;  6: fn = 6'h08;  15: fn = 6'h2A;
            default: fn = 6'(32 + k - 7);
         endcase
      end else fn = 6'($urandom_range(0, 63));
      if (op == 6'd0) return {6'd0, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
      return {op, rs, rt, 16'($urandom)};
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      dec_t d;
      logic exp_ready;
      logic [31:0] nb;

      tbl[0]  = '{32'h2008FFFF, 32'h00000100, 9'h048, 5'd8,  1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      tbl[1]  = '{32'h1022FFFF, 32'h00000200, 9'h0C4, 5'd0,  1'b0, 32'hFFFFFFFF, 32'h00000200, 1'b0};
      tbl[2]  = '{32'h08000040, 32'h10000000, 9'h102, 5'd0,  1'b0, 32'h00000040, 32'h10000100, 1'b0};
      tbl[3]  = '{32'h0FFFFFFF, 32'hFFFFFFFC, 9'h103, 5'd31, 1'b1, 32'hFFFFFFFF, 32'h0FFFFFFC, 1'b0};
      tbl[4]  = '{32'hFC000000, 32'h00000040, 9'h1FF, 5'd0,  1'b0, 32'h00000000, 32'h00000000, 1'b1};
      tbl[5]  = '{32'h00221805, 32'h00000044, 9'h1C5, 5'd0,  1'b0, 32'h00000000, 32'h00000000, 1'b1};
      tbl[6]  = '{32'h3C051234, 32'h00000048, 9'h04F, 5'd5,  1'b1, 32'h12340000, 32'h00000000, 1'b0};
      tbl[7]  = '{32'h34268001, 32'h0000004C, 9'h04D, 5'd6,  1'b1, 32'h00008001, 32'h00000000, 1'b0};
      tbl[8]  = '{32'hAC22FFF8, 32'h00000050, 9'h0AB, 5'd0,  1'b0, 32'hFFFFFFF8, 32'h00000000, 1'b0};
      tbl[9]  = '{32'h00022140, 32'h00000054, 9'h000, 5'd4,  1'b1, 32'h00000005, 32'h00000000, 1'b0};
      tbl[10] = '{32'h03E00008, 32'h00000058, 9'h008, 5'd0,  1'b0, 32'h00000000, 32'h00000000, 1'b0};
      tbl[11] = '{32'h8C600004, 32'h0000005C, 9'h0A3, 5'd0,  1'b0, 32'h00000004, 32'h00000000, 1'b0};
      tbl[12] = '{32'h14007FFF, 32'h7FFFFFFC, 9'h0C5, 5'd0,  1'b0, 32'h00007FFF, 32'h8001FFFC, 1'b0};
      tbl[13] = '{32'h00220021, 32'h00000060, 9'h021, 5'd0,  1'b0, 32'h00000000, 32'h00000000, 1'b0};

      do_reset();
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);

      for (int i = 0; i < 14; i++) begin
         do_reset();
         in_valid = 1; in_instr = tbl[i].instr; in_pc = tbl[i].pc;
         #1;
         chk($sformatf("tbl%0d_ready", i), in_ready, 1'b1);
         step();
         in_valid = 0;
         chk($sformatf("tbl%0d_valid", i),  out_valid, 1'b1);
         chk($sformatf("tbl%0d_alu", i),    out_alu_op, tbl[i].alu);
         chk($sformatf("tbl%0d_rd", i),     out_rd, tbl[i].rd);
         chk($sformatf("tbl%0d_wen", i),    out_wen, tbl[i].wen);
         chk($sformatf("tbl%0d_imm", i),    out_imm, tbl[i].imm);
         chk($sformatf("tbl%0d_target", i), out_target, tbl[i].target);
         chk($sformatf("tbl%0d_illegal", i), out_illegal, tbl[i].ill);
         chk($sformatf("tbl%0d_pc", i),     out_pc, tbl[i].pc);
      end

      // RAW stall on $3 released by writeback
      do_reset();
      in_valid = 1; in_instr = 32'h00221820; #1;
      chk("raw_first_ready", in_ready, 1'b1);
      step();
      in_instr = 32'h00632022; out_ready = 1; #1;
      chk("raw_held_ready", in_ready, 1'b0);
      step();
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("raw_busy_ready", in_ready, 1'b0);
         step();
      end
      wb_valid = 1; wb_rd = 5'd3; #1;
      chk("raw_wb_ready", in_ready, 1'b1);
      step();
      wb_valid = 0; in_valid = 0;
      chk("raw_accept_valid", out_valid, 1'b1);
      chk("raw_accept_rd", out_rd, 5'd4);

      // hold, then flush: busy state untouched by the squash
      do_reset();
      out_ready = 1; in_valid = 1; in_instr = 32'h2009FFFF; #1;
      step();
      in_instr = 32'h2008FFFF; #1;
      chk("hold_load_ready", in_ready, 1'b1);
      step();
      out_ready = 0; in_instr = 32'h34268001; #1;
      chk("hold_ready_c1", in_ready, 1'b0);
      step();
      chk("hold_stable", {out_valid, out_rd, out_imm, out_alu_op}, {1'b1, 5'd8, 32'hFFFFFFFF, 9'h048});
      flush = 1; #1;
      chk("hold_ready_c2", in_ready, 1'b0);
      step();
      flush = 0;
      chk("flush_valid", out_valid, 1'b0);
      in_instr = 32'h212A0001; #1;
      chk("flush_busy_kept", in_ready, 1'b0);
      in_instr = 32'h210B0001; #1;
      chk("flush_no_set", in_ready, 1'b1);
      in_valid = 0;
      step();
      in_valid = 1; in_instr = 32'h200C0001; #1;
      step();
      in_valid = 0; flush = 1; out_ready = 1; #1;
      step();
      flush = 0; out_ready = 0;
      chk("flush_handoff_valid", out_valid, 1'b0);
      in_valid = 1; in_instr = 32'h218D0001; #1;
      chk("flush_handoff_busy", in_ready, 1'b0);
      in_valid = 0;

      // illegal passes a busy source; reset mid-stall empties scoreboard
      do_reset();
      out_ready = 1; in_valid = 1; in_instr = 32'h20050001; #1;
      step();
      in_valid = 0; #1;
      step();
      in_valid = 1; in_instr = 32'h00A00005; #1;
      chk("illegal_no_stall", in_ready, 1'b1);
      step();
      chk("illegal_flags", {out_illegal, out_wen}, 2'b10);
      in_instr = 32'h20060001; #1;
      step();
      out_ready = 0; in_valid = 1; in_instr = 32'h20A70001; #1;
      chk("busy5_stall", in_ready, 1'b0);
      in_valid = 0;
      #2;
      reset_n = 0; #1;
      chk("reset_all_zero", {out_valid, out_alu_op, out_rs, out_rt, out_rd, out_wen,
                             out_imm, out_target, out_pc, out_illegal}, 128'd0);
      @(negedge clock);
      reset_n = 1;
      in_valid = 1; in_instr = 32'h20A70001; #1;
      chk("reset_sb_clear", in_ready, 1'b1);
      step();
      in_valid = 0;

      // randomized run against the model
      do_reset();
      m_busy = 32'd0; m_valid = 1'b0; m_held = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk("rnd_valid", out_valid, m_valid);
         if (m_valid)
            chk("rnd_fields",
                {out_alu_op, out_rs, out_rt, out_rd, out_wen, out_imm, out_target, out_pc, out_illegal},
                {m_held.alu, m_held.rs, m_held.rt, m_held.rd, m_held.wen, m_held.imm,
                 m_held.target, m_held.pc, m_held.ill});
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         wb_valid  = ($urandom_range(0, 9) < 3);
         wb_rd     = 5'($urandom_range(0, 7));
         in_instr  = rnd_instr();
         in_pc     = {$urandom} & 32'hFFFFFFFC;
         #1;
         d = ref_decode(in_instr, in_pc);
         exp_ready = (!m_valid || out_ready) && !flush &&
                     (d.ill || !((d.use_rs && blk(d.rs)) || (d.use_rt && blk(d.rt)) ||
                                 (d.wen && blk(d.rd))));
         chk("rnd_ready", in_ready, exp_ready);
         nb = m_busy;
         if (wb_valid) nb[wb_rd] = 1'b0;
         if (m_valid && out_ready && m_held.wen) nb[m_held.rd] = 1'b1;
         nb[0] = 1'b0;
         m_busy = nb;
         if (in_valid && exp_ready) begin
            m_held  = d;
            m_valid = 1'b1;
         end else if (flush || out_ready) begin
            m_valid = 1'b0;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage between instruction fetch and the integer ALUs. It accepts one 32-bit MIPS instruction and its PC per cycle over a valid/ready handshake, and splits it into fields, a 9-bit ALU opcode, an extended immediate and a branch/jump target. It holds the result in a one-entry output register for the execute stage. A 32-entry busy-bit scoreboard stalls the stage on RAW and WAW hazards until writeback releases the register.

## Interface
Parameters:
- none; all widths are fixed by the 32-bit ISA (`BITNESS).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- flush  in  1  squash the output register and block input this cycle (branch redirect)
- wb_valid  in  1  writeback completes this cycle
- wb_rd  in  5  register released by writeback
- out_valid  out  1  decoded instruction held for execute
- out_ready  in  1  execute consumes the held instruction
- out_alu_op  out  9  opcode for int_alu instr input
- out_rs, out_rt, out_rd  out  5 each  source registers and destination register
- out_wen  out  1  destination is written
- out_imm  out  32  extended immediate or shamt
- out_target  out  32  branch/jump target
- out_pc  out  32  PC of the held instruction
- out_illegal  out  1  unsupported opcode or funct

## Operation
- Opcode classes; all other opcodes are illegal:
  - R-type 0x00
  - J 0x02, JAL 0x03
  - branch 0x04–0x07
  - I-ALU 0x08–0x0F
  - load 0x20–0x25
  - store 0x28, 0x29, 0x2B
- out_alu_op = {class, 6 bits}:
  - R-type: {000, funct}
  - I-ALU: {001, opcode}
  - load/store: {010, opcode}
  - branch: {011, opcode}
  - J/JAL: {100, opcode}
  - illegal: {111, opcode}
- R-type funct is legal only for 0x00, 0x02, 0x03, 0x04, 0x06, 0x07, 0x08 (JR), 0x20–0x27, 0x2A, 0x2B. Any other funct sets illegal and gives {111, funct}.
- Destination register:
  - R-type: rd; JR: none
  - I-ALU and load: rt
  - JAL: 31
  - store, branch, J, illegal: none
- out_wen = 1 only if the class has a destination and that destination ≠ 0.
- Immediate:
  - ANDI/ORI/XORI: zero-extended imm16
  - LUI: imm16<<16
  - R-type: {27'b0, shamt}
  - everything else: sign-extended imm16
- Target:
  - branch: in_pc+4+(sext(imm16)<<2), modulo 2^32
  - J/JAL: {(in_pc+4)[31:28], idx26, 2'b00}
  - other classes: 0
- Sources used:
  - R-type, store, BEQ, BNE: rs and rt
  - I-ALU, load, BLEZ, BGTZ: rs
  - J/JAL: none
- Hazard is asserted when any used source or the destination (if wen) matches either of:
  - a busy bit that is set and not being cleared by wb this cycle;
  - out_rd of the held instruction, when out_valid && out_wen.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Scoreboard:
  - busy[d] is set when an instruction with wen leaves the output register (out_valid && out_ready).
  - busy[wb_rd] clears on wb_valid.
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is always 0.
- flush:
  - clears out_valid next edge and accepts nothing that cycle.
  - leaves busy bits unchanged; older instructions still write back.
  - If out_ready is high in the flush cycle, the handoff is still honoured and sets busy.
- Illegal instructions pass through with out_illegal=1, out_wen=0 and no hazard check.

## Timing
- Latency is 1 cycle. An accept at edge N gives out_valid=1 with decoded fields after edge N.
- Throughput is 1 instruction per cycle when there is no stall.
- The output register holds stable while out_valid && !out_ready.
- Reset (asynchronous, any cycle including mid-stall):
  - out_valid=0, all busy=0
  - out_alu_op, out_rs, out_rt, out_rd, out_imm, out_target, out_pc = 0
  - out_wen=0, out_illegal=0
  - in_ready rises after reset_n deasserts.
- A writeback in the same cycle as a hazard check counts as released, so the dependent instruction is accepted that cycle.

## Test plan
- ADDI $8,$0,-1 (0x2008FFFF) at pc 0x100 -> one cycle later:
  - out_alu_op=0x048, out_rd=8, out_wen=1
  - out_imm=0xFFFFFFFF, out_target=0
- BEQ $1,$2,-1 (0x1022FFFF) at pc 0x200 -> out_target=0x200, out_wen=0. J idx 0x40 at pc 0x10000000 -> out_target=0x10000100.
- ADD $3,$1,$2 consumed, then SUB $4,$3,$3 -> in_ready=0 until wb_valid with wb_rd=3; accepted in the wb cycle.
- Output register held with out_ready=0 for 3 cycles -> fields stable and in_ready=0. Flush in cycle 2 -> out_valid=0 next cycle and busy is unaffected.
- Opcode 0x3F and R-type funct 0x05 -> out_illegal=1, out_wen=0; the instruction passes without a stall.
- Assert reset_n low while busy[5]=1 and out_valid=1 -> all outputs 0 and the scoreboard is empty, so an instruction reading $5 is accepted immediately afterwards.
